ic_data_ecc_scrub_ctrl: RTL and testbench

IC_DATA_ECC_SCRUB_CTRL -- requirements
Module: ic_data_ecc_scrub_ctrl

---
 rtl/ic_data_ecc_scrub_ctrl.sv | 167 ++++++++++++++++
 tb/tb_ic_data_ecc_scrub_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ic_data_ecc_scrub_ctrl.sv
// IC data RAM ECC scrub controller: classifies decoder results, counts
// and logs errors, and writes corrected single-bit words back to the RAM.
module ic_data_ecc_scrub_ctrl #(
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_a,
  input  logic             chk_valid,
  input  logic [10:0]      chk_addr,
  input  logic             chk_sb_err,
  input  logic             chk_db_err,
  input  logic             chk_addr_err,
  input  logic [6:0]       chk_syndrome,
  input  logic [31:0]      chk_data,
  input  logic [7:0]       chk_ecc,
  input  logic             scrub_en,
  input  logic             err_clr,
  output logic             scrub_req,
  output logic [10:0]      scrub_addr,
  output logic [31:0]      scrub_wdata,
  output logic [7:0]       scrub_wecc,
  input  logic             scrub_ack,
  output logic             busy,
  output logic             fatal_err,
  output logic             scrub_fail,
  output logic [CNT_W-1:0] sb_cnt,
  output logic [CNT_W-1:0] db_cnt,
  output logic             log_valid,
  output logic [1:0]       log_type,
  output logic [10:0]      log_addr,
  output logic [6:0]       log_syndrome
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [1:0] EV_NONE = 2'b00;
  localparam logic [1:0] EV_SB   = 2'b01;
  localparam logic [1:0] EV_DB   = 2'b10;
  localparam logic [1:0] EV_ADDR = 2'b11;

  localparam logic [7:0] WAIT_LAST = 8'(ACK_TIMEOUT - 1);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0] state;
  logic [7:0] wait_cnt;
  logic [1:0] ev_type;
  logic       ev_any;
  logic       ev_sb;
  logic       ev_fatal;

  // Address errors outrank double errors, which outrank single errors.
  always_comb begin
    ev_type = EV_NONE;
    if (chk_valid) begin
      unique case (1'b1)
        chk_addr_err:
          ev_type = EV_ADDR;
        !chk_addr_err && chk_db_err:
          ev_type = EV_DB;
        !chk_addr_err && !chk_db_err
          && chk_sb_err:
          ev_type = EV_SB;
        default:
          ev_type = EV_NONE;
      endcase
    end
  end

  assign ev_any   = ev_type != EV_NONE;
  assign ev_sb    = ev_type == EV_SB;
  assign ev_fatal = ev_type[1];

  assign scrub_req = state == ST_REQ;
  assign busy      = state != ST_IDLE;

  always_ff @(posedge clk) begin
    if (rst_a) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      scrub_addr  <= '0;
      scrub_wdata <= '0;
      scrub_wecc  <= '0;
      scrub_fail  <= 1'b0;
    end else begin
      scrub_fail <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ev_sb && scrub_en) begin
            state       <= ST_REQ;
            wait_cnt    <= '0;
            scrub_addr  <= chk_addr;
            scrub_wdata <= chk_data;
            scrub_wecc  <= chk_ecc;
          end
        end
        ST_REQ: begin
          // An ack in the final wait cycle still counts as accepted.
          if (scrub_ack) begin
            state <= ST_DRAIN;
          end else if (wait_cnt == WAIT_LAST) begin
            state      <= ST_IDLE;
            scrub_fail <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_DRAIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_a) begin
      fatal_err <= 1'b0;
    end else begin
      fatal_err <= ev_fatal;
    end
  end

  // A same-cycle event survives a clear and becomes the first count.
  always_ff @(posedge clk) begin
    if (rst_a) begin
      sb_cnt <= '0;
      db_cnt <= '0;
    end else if (err_clr) begin
      sb_cnt <= ev_sb ? CNT_ONE : '0;
      db_cnt <= ev_fatal ? CNT_ONE : '0;
    end else begin
      if (ev_sb && sb_cnt != CNT_MAX) begin
        sb_cnt <= sb_cnt + CNT_ONE;
      end
      if (ev_fatal && db_cnt != CNT_MAX) begin
        db_cnt <= db_cnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_a) begin
      log_valid    <= 1'b0;
      log_type     <= '0;
      log_addr     <= '0;
      log_syndrome <= '0;
    end else if (ev_any && (err_clr || !log_valid)) begin
      log_valid    <= 1'b1;
      log_type     <= ev_type;
      log_addr     <= chk_addr;
      log_syndrome <= chk_syndrome;
    end else if (err_clr) begin
      log_valid    <= 1'b0;
      log_type     <= '0;
      log_addr     <= '0;
      log_syndrome <= '0;
    end
  end

endmodule

// File: tb/tb_ic_data_ecc_scrub_ctrl.sv
// Bench for ic_data_ecc_scrub_ctrl: reference model checked every cycle
// plus directed scenarios with literal expectations.
module tb_ic_data_ecc_scrub_ctrl;

  localparam int TMO   = 15;
  localparam int CW    = 8;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_a = 1'b1;
  logic          chk_valid = 1'b0;
  logic [10:0]   chk_addr = '0;
  logic          chk_sb_err = 1'b0;
  logic          chk_db_err = 1'b0;
  logic          chk_addr_err = 1'b0;
  logic [6:0]    chk_syndrome = '0;
  logic [31:0]   chk_data = '0;
  logic [7:0]    chk_ecc = '0;
  logic          scrub_en = 1'b0;
  logic          err_clr = 1'b0;
  logic          scrub_ack = 1'b0;
  logic          scrub_req;
  logic [10:0]   scrub_addr;
  logic [31:0]   scrub_wdata;
  logic [7:0]    scrub_wecc;
  logic          busy;
  logic          fatal_err;
  logic          scrub_fail;
  logic [CW-1:0] sb_cnt;
  logic [CW-1:0] db_cnt;
  logic          log_valid;
  logic [1:0]    log_type;
  logic [10:0]   log_addr;
  logic [6:0]    log_syndrome;

  ic_data_ecc_scrub_ctrl #(
    .ACK_TIMEOUT(TMO),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst_a(rst_a),
    .chk_valid(chk_valid),
    .chk_addr(chk_addr),
    .chk_sb_err(chk_sb_err),
    .chk_db_err(chk_db_err),
    .chk_addr_err(chk_addr_err),
    .chk_syndrome(chk_syndrome),
    .chk_data(chk_data),
    .chk_ecc(chk_ecc),
    .scrub_en(scrub_en),
    .err_clr(err_clr),
    .scrub_req(scrub_req),
    .scrub_addr(scrub_addr),
    .scrub_wdata(scrub_wdata),
    .scrub_wecc(scrub_wecc),
    .scrub_ack(scrub_ack),
    .busy(busy),
    .fatal_err(fatal_err),
    .scrub_fail(scrub_fail),
    .sb_cnt(sb_cnt),
    .db_cnt(db_cnt),
    .log_valid(log_valid),
    .log_type(log_type),
    .log_addr(log_addr),
    .log_syndrome(log_syndrome)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  // Reference model: a write-back is "outstanding" for some number of
  // cycles, then either accepted (one drain cycle) or given up on.
  bit   armed = 0;
  bit   m_out;
  bit   m_drain;
  int   m_waited;
  bit   m_fatal;
  bit   m_fail;
  int   m_sb;
  int   m_db;
  bit   m_lv;
  int   m_lt;
  int   m_la;
  int   m_ls;
  int   m_pa;
  int   m_pd;
  int   m_pe;
  int   t;

  always @(posedge clk) begin
    if (rst_a) begin
      armed = 1;
      m_out = 0; m_drain = 0; m_waited = 0;
      m_fatal = 0; m_fail = 0;
      m_sb = 0; m_db = 0;
      m_lv = 0; m_lt = 0; m_la = 0; m_ls = 0;
      m_pa = 0; m_pd = 0; m_pe = 0;
    end else begin
      t = 0;
      if (chk_valid) begin
        if (chk_addr_err) t = 3;
        else if (chk_db_err) t = 2;
        else if (chk_sb_err) t = 1;
      end
      m_fatal = (t >= 2);
      m_fail = 0;
      if (m_drain) begin
        m_drain = 0;
      end else if (m_out) begin
        if (scrub_ack) begin
          m_out = 0;
          m_drain = 1;
        end else begin
          m_waited++;
          if (m_waited == TMO) begin
            m_out = 0;
            m_fail = 1;
          end
        end
      end else if (t == 1 && scrub_en) begin
        m_out = 1;
        m_waited = 0;
        m_pa = int'(chk_addr);
        m_pd = int'(chk_data);
        m_pe = int'(chk_ecc);
      end
      if (err_clr) begin
        m_sb = (t == 1) ? 1 : 0;
        m_db = (t >= 2) ? 1 : 0;
        m_lv = 0; m_lt = 0; m_la = 0; m_ls = 0;
      end else begin
        if (t == 1) m_sb = (m_sb < CMAX) ? m_sb + 1 : CMAX;
        if (t >= 2) m_db = (m_db < CMAX) ? m_db + 1 : CMAX;
      end
      if (t != 0 && !m_lv) begin
        m_lv = 1;
        m_lt = t;
        m_la = int'(chk_addr);
        m_ls = int'(chk_syndrome);
      end
    end
  end

  int req_hi = 0;
  int fail_n = 0;
  int fatal_n = 0;

  always @(negedge clk) begin
    if (armed) begin
      chk("scrub_req", 64'(scrub_req), 64'(m_out));
      chk("busy", 64'(busy), 64'(m_out | m_drain));
      chk("fatal_err", 64'(fatal_err), 64'(m_fatal));
      chk("scrub_fail", 64'(scrub_fail), 64'(m_fail));
      chk("sb_cnt", 64'(sb_cnt), 64'(m_sb));
      chk("db_cnt", 64'(db_cnt), 64'(m_db));
      chk("log_valid", 64'(log_valid), 64'(m_lv));
      chk("log_type", 64'(log_type), 64'(m_lt));
      chk("log_addr", 64'(log_addr), 64'(m_la));
      chk("log_syn", 64'(log_syndrome), 64'(m_ls));
      chk("scrub_addr", 64'(scrub_addr), 64'(m_pa));
      chk("scrub_wdata", 64'(scrub_wdata),
          64'(unsigned'(m_pd)));
      chk("scrub_wecc", 64'(scrub_wecc), 64'(m_pe));
      if (scrub_req) req_hi++;
      if (scrub_fail) fail_n++;
      if (fatal_err) fatal_n++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ev(input logic [10:0] a,
                    input logic [2:0]  f,
                    input logic [6:0]  syn,
                    input logic [31:0] d,
                    input logic [7:0]  e);
    chk_valid = 1'b1;
    chk_addr = a;
    {chk_addr_err, chk_db_err, chk_sb_err} = f;
    chk_syndrome = syn;
    chk_data = d;
    chk_ecc = e;
    step();
    chk_valid = 1'b0;
    {chk_addr_err, chk_db_err, chk_sb_err} = 3'b000;
  endtask

  int b_req;
  int b_fail;
  int b_fatal;

  initial begin
    step();
    step();
    rst_a = 1'b0;
    chk("rst scrub_req", 64'(scrub_req), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst sb_cnt", 64'(sb_cnt), 64'd0);
    chk("rst log_valid", 64'(log_valid), 64'd0);

    // single error, ack in third request cycle
    scrub_en = 1'b1;
    b_req = req_hi;
    ev(11'h155, 3'b001, 7'h2C, 32'hDEADBEEF, 8'h5A);
    chk("s1 wdata", 64'(scrub_wdata), 64'hDEADBEEF);
    step();
    step();
    scrub_ack = 1'b1;
    step();
    scrub_ack = 1'b0;
    chk("s1 drain busy", 64'(busy), 64'd1);
    step();
    chk("s1 idle busy", 64'(busy), 64'd0);
    chk("s1 req cycles", 64'(req_hi - b_req), 64'd3);
    chk("s1 sb_cnt", 64'(sb_cnt), 64'd1);
    chk("s1 log_type", 64'(log_type), 64'd1);
    chk("s1 log_addr", 64'(log_addr), 64'h155);

    // stray ack and flags without valid are ignored
    scrub_ack = 1'b1;
    step();
    scrub_ack = 1'b0;
    chk_sb_err = 1'b1;
    chk_db_err = 1'b1;
    step();
    chk_sb_err = 1'b0;
    chk_db_err = 1'b0;
    chk("ign sb_cnt", 64'(sb_cnt), 64'd1);
    chk("ign db_cnt", 64'(db_cnt), 64'd0);

    // double error never scrubs
    b_req = req_hi;
    b_fatal = fatal_n;
    ev(11'h7FF, 3'b010, 7'h33, 32'h1, 8'h1);
    chk("s2 fatal", 64'(fatal_err), 64'd1);
    chk("s2 db_cnt", 64'(db_cnt), 64'd1);
    repeat (4) step();
    chk("s2 fatal pulses", 64'(fatal_n - b_fatal), 64'd1);
    chk("s2 no req", 64'(req_hi - b_req), 64'd0);
    chk("s2 log kept", 64'(log_addr), 64'h155);

    // timeout, with enable dropped and an event while busy
    b_req = req_hi;
    b_fail = fail_n;
    ev(11'h0AA, 3'b001, 7'h05, 32'hCAFEF00D, 8'h3C);
    scrub_en = 1'b0;
    step();
    ev(11'h0BB, 3'b001, 7'h06, 32'h12345678, 8'h11);
    repeat (20) step();
    chk("s3 req cycles", 64'(req_hi - b_req), 64'd15);
    chk("s3 fail pulses", 64'(fail_n - b_fail), 64'd1);
    chk("s3 busy", 64'(busy), 64'd0);
    chk("s3 addr held", 64'(scrub_addr), 64'h0AA);
    chk("s3 sb_cnt", 64'(sb_cnt), 64'd3);

    // ack in the timeout cycle wins
    scrub_en = 1'b1;
    b_req = req_hi;
    b_fail = fail_n;
    ev(11'h123, 3'b001, 7'h07, 32'h0, 8'h0);
    repeat (14) step();
    scrub_ack = 1'b1;
    step();
    scrub_ack = 1'b0;
    chk("s4 drain", 64'(busy), 64'd1);
    step();
    chk("s4 no fail", 64'(fail_n - b_fail), 64'd0);
    chk("s4 req cycles", 64'(req_hi - b_req), 64'd15);

    // reset mid-request
    b_req = req_hi;
    b_fail = fail_n;
    ev(11'h321, 3'b001, 7'h08, 32'hAAAA5555, 8'h77);
    step();
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    chk("s5 req", 64'(scrub_req), 64'd0);
    chk("s5 sb_cnt", 64'(sb_cnt), 64'd0);
    chk("s5 log_valid", 64'(log_valid), 64'd0);
    chk("s5 addr", 64'(scrub_addr), 64'd0);
    repeat (3) step();
    chk("s5 no fail", 64'(fail_n - b_fail), 64'd0);
    b_req = req_hi;
    ev(11'h042, 3'b001, 7'h09, 32'h0BADC0DE, 8'h21);
    scrub_ack = 1'b1;
    step();
    scrub_ack = 1'b0;
    step();
    chk("s5 after req", 64'(req_hi - b_req), 64'd1);
    chk("s5 after sb", 64'(sb_cnt), 64'd1);
    chk("s5 after log", 64'(log_addr), 64'h042);

    // saturation with scrub disabled
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr sb_cnt", 64'(sb_cnt), 64'd0);
    chk("clr log_valid", 64'(log_valid), 64'd0);
    scrub_en = 1'b0;
    for (int i = 0; i < 300; i++) begin
      ev(11'(i + 1), 3'b001, 7'(i + 5),
         32'(i), 8'(i));
    end
    chk("sat sb_cnt", 64'(sb_cnt), 64'd255);
    chk("sat log_addr", 64'(log_addr), 64'd1);
    chk("sat log_syn", 64'(log_syndrome), 64'd5);
    chk("sat busy", 64'(busy), 64'd0);

    // clear coincident with an address error
    err_clr = 1'b1;
    ev(11'h2A0, 3'b100, 7'h7F, 32'h0, 8'h0);
    err_clr = 1'b0;
    chk("clr+ev type", 64'(log_type), 64'd3);
    chk("clr+ev addr", 64'(log_addr), 64'h2A0);
    chk("clr+ev db", 64'(db_cnt), 64'd1);
    chk("clr+ev sb", 64'(sb_cnt), 64'd0);
    chk("clr+ev fatal", 64'(fatal_err), 64'd1);

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
